// File: rtl/instr_exec_unit.sv
// -----------------------------------------------------------------------------
// instr_exec_unit
//
// Receiving end of the instruction interface. Every valid beat is accepted
// (there is no backpressure) and is executed against an internal register
// file. The pipeline has three stages:
//   S1  capture         : beat fields registered on the sampling edge T
//   S2  operand read    : register-file operands (with S2 result bypass)
//                         registered at T+1
//   EX  execute / wb    : ALU result written to the register file, and the
//                         wb_* / illegal_op pulses registered at T+2
//
// Ports
//   clk          clock, all logic on the rising edge
//   reset        synchronous, active-high; clears pipeline, outputs,
//                counters and reloads reg[i] = i
//   valid        instruction beat present on this edge
//   rs0, rs1     source register indices
//   rd           destination register index
//   opcode       operation (0..10 legal, 11..15 illegal)
//   wb_valid     one-cycle pulse: a result was produced
//   wb_rd        destination of that result
//   wb_data      the result
//   illegal_op   one-cycle pulse: an undefined opcode retired
//   retired_cnt  legal instructions retired (NOP included), wraps
//   illegal_cnt  illegal instructions seen, wraps
// -----------------------------------------------------------------------------
module instr_exec_unit #(
    parameter int REG_WIDTH  = 5,
    parameter int OP_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [REG_WIDTH-1:0]  rs0,
    input  logic [REG_WIDTH-1:0]  rs1,
    input  logic [REG_WIDTH-1:0]  rd,
    input  logic [OP_WIDTH-1:0]   opcode,
    output logic                  wb_valid,
    output logic [REG_WIDTH-1:0]  wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  illegal_op,
    output logic [CNT_WIDTH-1:0]  retired_cnt,
    output logic [CNT_WIDTH-1:0]  illegal_cnt
);

    localparam int NUM_REGS = 2 ** REG_WIDTH;
    localparam int SH_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [OP_WIDTH-1:0] OP_NOP  = OP_WIDTH'(4'd0);
    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(4'd1);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(4'd2);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(4'd3);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(4'd4);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(4'd5);
    localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(4'd6);
    localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(4'd7);
    localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(4'd8);
    localparam logic [OP_WIDTH-1:0] OP_INC  = OP_WIDTH'(4'd9);
    localparam logic [OP_WIDTH-1:0] OP_MOV  = OP_WIDTH'(4'd10);

    localparam logic [REG_WIDTH-1:0]  REG_ZERO  = {REG_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // S1: captured beat
    logic                  s1_valid_r;
    logic [REG_WIDTH-1:0]  s1_rs0_r;
    logic [REG_WIDTH-1:0]  s1_rs1_r;
    logic [REG_WIDTH-1:0]  s1_rd_r;
    logic [OP_WIDTH-1:0]   s1_op_r;

    // S2: operands resolved
    logic                  s2_valid_r;
    logic [DATA_WIDTH-1:0] s2_a_r;
    logic [DATA_WIDTH-1:0] s2_b_r;
    logic [REG_WIDTH-1:0]  s2_rd_r;
    logic [OP_WIDTH-1:0]   s2_op_r;

    // Register file; entry 0 is never written so it stays at its reset value 0
    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

    // Combinational helpers
    logic [DATA_WIDTH-1:0] alu_s;
    logic                  legal_s;     // opcode is defined
    logic                  produces_s;  // opcode produces a result (legal, not NOP)
    logic                  commit_s;    // S2 result lands in the register file
    logic [DATA_WIDTH-1:0] op_a_s;
    logic [DATA_WIDTH-1:0] op_b_s;

    // Stage S1/S2 pipeline registers; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_rs0_r   <= REG_ZERO;
            s1_rs1_r   <= REG_ZERO;
            s1_rd_r    <= REG_ZERO;
            s1_op_r    <= OP_NOP;
            s2_valid_r <= 1'b0;
            s2_a_r     <= DATA_ZERO;
            s2_b_r     <= DATA_ZERO;
            s2_rd_r    <= REG_ZERO;
            s2_op_r    <= OP_NOP;
        end else begin
            s1_valid_r <= valid;
            s1_rs0_r   <= rs0;
            s1_rs1_r   <= rs1;
            s1_rd_r    <= rd;
            s1_op_r    <= opcode;
            s2_valid_r <= s1_valid_r;
            s2_a_r     <= op_a_s;
            s2_b_r     <= op_b_s;
            s2_rd_r    <= s1_rd_r;
            s2_op_r    <= s1_op_r;
        end
    end

    // ALU and opcode decode for the instruction sitting in S2
    always_comb begin
        alu_s      = DATA_ZERO;
        legal_s    = 1'b1;
        produces_s = 1'b1;
        case (s2_op_r)
            OP_NOP:  produces_s = 1'b0;
            OP_ADD:  alu_s = s2_a_r + s2_b_r;
            OP_SUB:  alu_s = s2_a_r - s2_b_r;
            OP_AND:  alu_s = s2_a_r & s2_b_r;
            OP_OR:   alu_s = s2_a_r | s2_b_r;
            OP_XOR:  alu_s = s2_a_r ^ s2_b_r;
            OP_SLL:  alu_s = s2_a_r << s2_b_r[SH_W-1:0];
            OP_SRL:  alu_s = s2_a_r >> s2_b_r[SH_W-1:0];
            OP_SLTU: alu_s = (s2_a_r < s2_b_r) ? DATA_ONE : DATA_ZERO;
            OP_INC:  alu_s = s2_a_r + DATA_ONE;
            OP_MOV:  alu_s = s2_a_r;
            default: begin
                legal_s    = 1'b0;
                produces_s = 1'b0;
            end
        endcase
    end

    // A result only reaches the register file for a real destination; r0
    // writes still pulse wb_valid but leave the file (and the bypass) alone.
    assign commit_s = s2_valid_r & produces_s & (s2_rd_r != REG_ZERO);

    // S1 operand read: r0 reads as zero, otherwise the S2 result wins over the
    // stale register-file value when it targets the same register. Anything
    // older than S2 has already been written back on this edge's predecessor.
    always_comb begin
        op_a_s = DATA_ZERO;
        op_b_s = DATA_ZERO;
        if (s1_rs0_r == REG_ZERO) begin
            op_a_s = DATA_ZERO;
        end else if (commit_s && (s2_rd_r == s1_rs0_r)) begin
            op_a_s = alu_s;
        end else begin
            op_a_s = regs_r[s1_rs0_r];
        end
        if (s1_rs1_r == REG_ZERO) begin
            op_b_s = DATA_ZERO;
        end else if (commit_s && (s2_rd_r == s1_rs1_r)) begin
            op_b_s = alu_s;
        end else begin
            op_b_s = regs_r[s1_rs1_r];
        end
    end

    // Register file: reload reg[i] = i on reset, write back committed results
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= DATA_WIDTH'(i);
            end
        end else if (commit_s) begin
            regs_r[s2_rd_r] <= alu_s;
        end
    end

    // Write-back / illegal pulses and retirement counters
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_rd       <= REG_ZERO;
            wb_data     <= DATA_ZERO;
            illegal_op  <= 1'b0;
            retired_cnt <= CNT_ZERO;
            illegal_cnt <= CNT_ZERO;
        end else begin
            wb_valid   <= s2_valid_r & produces_s;
            illegal_op <= s2_valid_r & ~legal_s;
            if (s2_valid_r && produces_s) begin
                wb_rd   <= s2_rd_r;
                wb_data <= alu_s;
            end
            if (s2_valid_r && legal_s) begin
                retired_cnt <= retired_cnt + CNT_ONE;
            end
            if (s2_valid_r && !legal_s) begin
                illegal_cnt <= illegal_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_exec_unit
// Directed stimulus with hand-computed results. Each issued instruction that
// should produce a wb or illegal pulse pushes its expectation into a queue;
// an independent monitor pops and compares whenever a pulse appears.
// -----------------------------------------------------------------------------
module tb_instr_exec_unit;

    localparam int RW = 5;
    localparam int OW = 4;
    localparam int DW = 32;
    localparam int CW = 16;

    localparam logic [3:0] NOP  = 4'd0;
    localparam logic [3:0] ADD  = 4'd1;
    localparam logic [3:0] SUB  = 4'd2;
    localparam logic [3:0] AND_ = 4'd3;
    localparam logic [3:0] OR_  = 4'd4;
    localparam logic [3:0] XOR_ = 4'd5;
    localparam logic [3:0] SLL  = 4'd6;
    localparam logic [3:0] SRL  = 4'd7;
    localparam logic [3:0] SLTU = 4'd8;
    localparam logic [3:0] INC  = 4'd9;
    localparam logic [3:0] MOV  = 4'd10;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid;
    logic [RW-1:0] rs0, rs1, rd;
    logic [OW-1:0] opcode;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          illegal_op;
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] illegal_cnt;

    instr_exec_unit #(
        .REG_WIDTH(RW), .OP_WIDTH(OW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid),
        .rs0(rs0), .rs1(rs1), .rd(rd), .opcode(opcode),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal_op(illegal_op), .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        bit            ill;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        logic [CW-1:0] ret;
        logic [CW-1:0] illc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor: every output pulse must match the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid || illegal_op) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pulse: got wb_valid=%0b illegal_op=%0b wb_rd=%0d wb_data=0x%h, required no pulse",
                             wb_valid, illegal_op, wb_rd, wb_data);
                end else begin
                    e = sb.pop_front();
                    if (wb_valid !== !e.ill || illegal_op !== e.ill ||
                        (!e.ill && (wb_rd !== e.rd || wb_data !== e.data)) ||
                        retired_cnt !== e.ret || illegal_cnt !== e.illc) begin
                        n_err++;
                        $display("FAIL %s: got wb_valid=%0b illegal_op=%0b rd=%0d data=0x%h ret=%0d ill=%0d, required wb_valid=%0b illegal_op=%0b rd=%0d data=0x%h ret=%0d ill=%0d",
                                 e.tag, wb_valid, illegal_op, wb_rd, wb_data, retired_cnt, illegal_cnt,
                                 !e.ill, e.ill, e.rd, e.data, e.ret, e.illc);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%h, required 0x%h", tag, act, req);
        end
    endtask

    // Drive one beat on the next edge; optionally record the expected result
    task automatic issue(input string tag, input logic [3:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input bit push,
                         input bit ill, input logic [31:0] data,
                         input logic [15:0] ret, input logic [15:0] illc);
        exp_t e;
        valid = 1'b1; opcode = op; rs0 = a; rs1 = b; rd = d;
        if (push) begin
            e.tag = tag; e.ill = ill; e.rd = d; e.data = data; e.ret = ret; e.illc = illc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic exec(input string tag, input logic [3:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic [31:0] data,
                        input logic [15:0] ret, input logic [15:0] illc);
        issue(tag, op, a, b, d, 1'b1, 1'b0, data, ret, illc);
    endtask

    task automatic bubble();
        valid  = 1'b0;
        opcode = OW'($urandom);
        rs0    = RW'($urandom);
        rs1    = RW'($urandom);
        rd     = RW'($urandom);
        @(posedge clk); #1;
    endtask

    // Bounded wait for all expected pulses
    task automatic drain(input string tag);
        repeat (4) bubble();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d pending results, required 0", tag, sb.size());
            sb.delete();
        end
    endtask

    // One reset edge with a live-looking beat on the inputs, which must be ignored
    task automatic do_reset(input string tag);
        reset = 1'b1; valid = 1'b1; opcode = ADD; rs0 = 5'd31; rs1 = 5'd31; rd = 5'd5;
        @(posedge clk); #1;
        reset = 1'b0; valid = 1'b0;
        check({tag, "_wb_valid"},    64'(wb_valid),    64'd0);
        check({tag, "_illegal_op"},  64'(illegal_op),  64'd0);
        check({tag, "_retired_cnt"}, 64'(retired_cnt), 64'd0);
        check({tag, "_illegal_cnt"}, 64'(illegal_cnt), 64'd0);
        check({tag, "_wb_data"},     64'(wb_data),     64'd0);
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; opcode = 4'd0; rs0 = 5'd0; rs1 = 5'd0; rd = 5'd0;
        do_reset("reset0");

        // Basic ADD
        exec("add_basic", ADD, 5'd3, 5'd4, 5'd5, 32'd7, 16'd1, 16'd0);
        drain("t1");

        // Back-to-back dependency through the bypass (r5 reset to 5)
        do_reset("reset1");
        exec("bp_add", ADD, 5'd3, 5'd4, 5'd5, 32'd7, 16'd1, 16'd0);
        exec("bp_sub", SUB, 5'd5, 5'd1, 5'd6, 32'd6, 16'd2, 16'd0);

        // Two slots apart: through the register file
        exec("rf_add", ADD, 5'd3, 5'd4, 5'd10, 32'd7, 16'd3, 16'd0);
        bubble();
        exec("rf_mov", MOV, 5'd10, 5'd0, 5'd7, 32'd7, 16'd4, 16'd0);

        // r0 destination: pulses but never writes or bypasses
        exec("r0_inc",  INC, 5'd31, 5'd0, 5'd0, 32'd32, 16'd5, 16'd0);
        exec("r0_read", MOV, 5'd0,  5'd0, 5'd1, 32'd0,  16'd6, 16'd0);
        drain("t3");

        // Illegal opcodes: no write, no bypass, only illegal counter moves
        issue("ill_12", 4'd12, 5'd3, 5'd4, 5'd2, 1'b1, 1'b1, 32'd0, 16'd6, 16'd1);
        exec("ill_nobp", MOV, 5'd2, 5'd0, 5'd9, 32'd2, 16'd7, 16'd1);
        bubble();
        exec("ill_norf", MOV, 5'd2, 5'd0, 5'd8, 32'd2, 16'd8, 16'd1);
        issue("ill_11", 4'd11, 5'd1, 5'd1, 5'd3, 1'b1, 1'b1, 32'd0, 16'd8, 16'd2);
        issue("ill_15", 4'd15, 5'd1, 5'd1, 5'd3, 1'b1, 1'b1, 32'd0, 16'd8, 16'd3);
        // NOP retires silently and does not bypass into the next read
        issue("nop", NOP, 5'd1, 5'd1, 5'd3, 1'b0, 1'b0, 32'd0, 16'd0, 16'd0);
        exec("after_nop", MOV, 5'd3, 5'd0, 5'd11, 32'd3, 16'd10, 16'd3);
        drain("t4");

        // Reset with an ADD in flight: dropped, r5 keeps its reset value
        issue("inflight", ADD, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 32'd0, 16'd0, 16'd0);
        do_reset("reset2");
        exec("post_rst", MOV, 5'd5, 5'd0, 5'd8, 32'd5, 16'd1, 16'd0);

        // Remaining ALU operations and edge cases
        exec("sll",      SLL,  5'd3,  5'd4,  5'd9,  32'd48,         16'd2,  16'd0);
        exec("srl",      SRL,  5'd31, 5'd1,  5'd9,  32'd15,         16'd3,  16'd0);
        exec("sltu_t",   SLTU, 5'd3,  5'd4,  5'd12, 32'd1,          16'd4,  16'd0);
        exec("sltu_f",   SLTU, 5'd4,  5'd3,  5'd13, 32'd0,          16'd5,  16'd0);
        exec("sub_wrap", SUB,  5'd1,  5'd2,  5'd14, 32'hFFFF_FFFF,  16'd6,  16'd0);
        exec("xor",      XOR_, 5'd6,  5'd3,  5'd15, 32'd5,          16'd7,  16'd0);
        exec("or",       OR_,  5'd8,  5'd2,  5'd16, 32'd7,          16'd8,  16'd0);
        exec("and",      AND_, 5'd6,  5'd7,  5'd17, 32'd6,          16'd9,  16'd0);
        exec("sll_max",  SLL,  5'd3,  5'd31, 5'd18, 32'h8000_0000,  16'd10, 16'd0);
        exec("srl_max",  SRL,  5'd14, 5'd31, 5'd19, 32'd1,          16'd11, 16'd0);
        exec("add_wrap", ADD,  5'd14, 5'd1,  5'd20, 32'd0,          16'd12, 16'd0);
        exec("bp_rs1",   ADD,  5'd1,  5'd20, 5'd21, 32'd1,          16'd13, 16'd0);
        drain("t6");

        // Retired counter wrap
        do_reset("reset3");
        valid = 1'b1; opcode = NOP; rs0 = 5'd0; rs1 = 5'd0; rd = 5'd0;
        repeat (65535) @(posedge clk);
        #1;
        valid = 1'b0;
        drain("wrap_a");
        check("retired_all_ones", 64'(retired_cnt), 64'hFFFF);
        issue("last_nop", NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 16'd0, 16'd0);
        drain("wrap_b");
        check("retired_wrap", 64'(retired_cnt), 64'd0);
        check("illegal_after_wrap", 64'(illegal_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
